// File: rtl/sample_rate_strobe_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : sample_rate_strobe_gen_if
// Description : Control/status bundle between the playback speed keys, the
//               sample strobe generator and its consumers.
// Revision    : 1.0 - initial release
// ============================================================================
interface sample_rate_strobe_gen_if #(
    parameter int DIV_W = 16
) ();
    logic             enable;
    logic             speed_up;
    logic             speed_down;
    logic             speed_reset;
    logic             sync_clk;
    logic [DIV_W-1:0] divisor;
    logic             at_min;
    logic             at_max;

    // Side that drives the keys/enable and consumes the strobe.
    modport master (
        output enable, speed_up, speed_down, speed_reset,
        input  sync_clk, divisor, at_min, at_max
    );

    // The strobe generator itself.
    modport slave (
        input  enable, speed_up, speed_down, speed_reset,
        output sync_clk, divisor, at_min, at_max
    );
endinterface
`default_nettype wire

// File: rtl/sample_rate_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module      : sample_rate_strobe_gen
// Description : Programmable clk divider producing a one-cycle sample strobe.
//               Speed keys (asynchronous levels) are synchronised and
//               edge-detected; each edge steps the divisor with saturation.
//               enable pauses the count without losing its phase.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_rate_strobe_gen #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 2273,
    parameter int STEP_DIV    = 64,
    parameter int MIN_DIV     = 568,
    parameter int MAX_DIV     = 9090
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    sample_rate_strobe_gen_if.slave      bus
);

    localparam logic [DIV_W-1:0] c_default  = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] c_min      = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] c_max      = DIV_W'(MAX_DIV);
    localparam logic [DIV_W-1:0] c_step     = DIV_W'(STEP_DIV);
    localparam logic [DIV_W:0]   c_step_ext = (DIV_W+1)'(STEP_DIV);
    localparam logic [DIV_W:0]   c_max_ext  = (DIV_W+1)'(MAX_DIV);
    // divisor - STEP < MIN  <=>  divisor < MIN + STEP; this form cannot wrap.
    localparam logic [DIV_W:0]   c_up_floor = (DIV_W+1)'(MIN_DIV) + c_step_ext;

    // Key bit order: [2] speed_reset, [1] speed_down, [0] speed_up.
    logic [2:0]       w_keys;
    logic [2:0]       r_s1;
    logic [2:0]       r_s2;
    logic [2:0]       r_s3;
    logic [2:0]       w_edge;

    logic [DIV_W-1:0] r_divisor;
    logic [DIV_W-1:0] w_div_next;
    logic [DIV_W:0]   w_div_ext;
    logic [DIV_W:0]   w_inc;
    logic [DIV_W-1:0] w_dec;
    logic [DIV_W-1:0] w_div_m1;

    logic [DIV_W-1:0] r_count;
    logic             r_strobe;

    assign w_keys = {bus.speed_reset, bus.speed_down, bus.speed_up};
    assign w_edge = r_s2 & ~r_s3;

    // Two-flop synchroniser plus history register for each key.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 3'b000;
            r_s2 <= 3'b000;
            r_s3 <= 3'b000;
        end else begin
            r_s1 <= w_keys;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_div_ext = {1'b0, r_divisor};
    assign w_inc     = w_div_ext + c_step_ext;
    assign w_dec     = r_divisor - c_step;

    // Next divisor: speed_reset beats speed_up beats speed_down, both saturating.
    always_comb begin
        w_div_next = r_divisor;
        if (w_edge[2]) begin
            w_div_next = c_default;
        end else if (w_edge[0]) begin
            w_div_next = (w_div_ext < c_up_floor) ? c_min : w_dec;
        end else if (w_edge[1]) begin
            w_div_next = (w_inc > c_max_ext) ? c_max : w_inc[DIV_W-1:0];
        end
    end

    // Divisor register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_divisor <= c_default;
        end else begin
            r_divisor <= w_div_next;
        end
    end

    assign w_div_m1 = r_divisor - DIV_W'(1);

    // Counter/strobe; >= lets a shrunken divisor fire on the next enabled cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_strobe <= 1'b0;
        end else if (!bus.enable) begin
            r_strobe <= 1'b0;
        end else if (r_count >= w_div_m1) begin
            r_count  <= '0;
            r_strobe <= 1'b1;
        end else begin
            r_count  <= r_count + DIV_W'(1);
            r_strobe <= 1'b0;
        end
    end

    assign bus.sync_clk = r_strobe;
    assign bus.divisor  = r_divisor;
    assign bus.at_min   = (r_divisor == c_min);
    assign bus.at_max   = (r_divisor == c_max);

endmodule
`default_nettype wire

// File: tb/tb_sample_rate_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_rate_strobe_gen
// Description : Directed bench; stimulus queues the expected strobe cycle and
//               divisor, a monitor pops and compares on every strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_rate_strobe_gen;

    localparam int c_div_w = 8;

    typedef struct {
        int unsigned        cyc;
        logic [c_div_w-1:0] div;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        q[$];

    sample_rate_strobe_gen_if #(.DIV_W(c_div_w)) bus ();

    sample_rate_strobe_gen #(
        .DIV_W      (c_div_w),
        .DEFAULT_DIV(10),
        .STEP_DIV   (2),
        .MIN_DIV    (4),
        .MAX_DIV    (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Free-running cycle index; a strobe set at posedge N is seen with cyc == N.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        if (bus.sync_clk === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: got strobe at cycle %0d, required none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.cyc != cyc || e.div !== bus.divisor) begin
                    bad++;
                    $display("FAIL strobe: got cycle %0d div %0d, required cycle %0d div %0d",
                             cyc, bus.divisor, e.cyc, e.div);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push(input int unsigned c, input logic [c_div_w-1:0] d);
        exp_t e;
        e.cyc = c;
        e.div = d;
        q.push_back(e);
    endtask

    task automatic drain(input string name);
        check(name, q.size(), 0);
        q.delete();
    endtask

    task automatic do_reset();
        bus.enable = 1'b0;
        reset      = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    // k = {speed_reset, speed_down, speed_up}
    task automatic pulse(input logic [2:0] k);
        {bus.speed_reset, bus.speed_down, bus.speed_up} = k;
        tick(2);
        {bus.speed_reset, bus.speed_down, bus.speed_up} = 3'b000;
        tick(4);
    endtask

    initial begin
        int unsigned p;
        int unsigned r;
        logic [c_div_w-1:0] div_seq [4];
        logic               min_seq [4];
        logic [c_div_w-1:0] up_seq  [4];
        logic               max_seq [4];
        div_seq = '{8'd8, 8'd6, 8'd4, 8'd4};
        min_seq = '{1'b0, 1'b0, 1'b1, 1'b1};
        up_seq  = '{8'd14, 8'd16, 8'd16, 8'd16};
        max_seq = '{1'b0, 1'b1, 1'b1, 1'b1};

        bus.enable      = 1'b0;
        bus.speed_up    = 1'b0;
        bus.speed_down  = 1'b0;
        bus.speed_reset = 1'b0;

        // 1: reset state and default period of 10
        do_reset();
        check("rst_div", bus.divisor, 10);
        check("rst_at_min", bus.at_min, 0);
        check("rst_at_max", bus.at_max, 0);
        check("rst_sync_clk", bus.sync_clk, 0);
        p = cyc;
        bus.enable = 1'b1;
        push(p + 10, 10); push(p + 20, 10); push(p + 30, 10);
        tick(35);
        bus.enable = 1'b0;
        drain("t1_drain");

        // 2: speed_up steps down to MIN and saturates; period 4
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pulse(3'b001);
            check($sformatf("t2_div%0d", i), bus.divisor, div_seq[i]);
            check($sformatf("t2_min%0d", i), bus.at_min, min_seq[i]);
        end
        p = cyc;
        bus.enable = 1'b1;
        push(p + 4, 4); push(p + 8, 4); push(p + 12, 4); push(p + 16, 4);
        tick(18);
        bus.enable = 1'b0;
        drain("t2_drain");

        // 3: held speed_down gives one step; then saturate at MAX
        do_reset();
        bus.speed_down = 1'b1;
        tick(20);
        check("t3_held", bus.divisor, 12);
        bus.speed_down = 1'b0;
        tick(4);
        check("t3_release", bus.divisor, 12);
        for (int i = 0; i < 4; i++) begin
            pulse(3'b010);
            check($sformatf("t3_div%0d", i), bus.divisor, up_seq[i]);
            check($sformatf("t3_max%0d", i), bus.at_max, max_seq[i]);
        end
        p = cyc;
        bus.enable = 1'b1;
        push(p + 16, 16); push(p + 32, 16);
        tick(34);
        bus.enable = 1'b0;
        drain("t3_drain");

        // 4: pause at count 3 for 50 cycles; strobe 7 cycles after resume
        do_reset();
        p = cyc;
        bus.enable = 1'b1;
        tick(3);
        bus.enable = 1'b0;
        tick(50);
        r = cyc;
        bus.enable = 1'b1;
        push(r + 7, 10); push(r + 17, 10);
        tick(19);
        bus.enable = 1'b0;
        drain("t4_drain");

        // 5: divisor 12, count 10, speed_reset -> strobe next enabled cycle
        do_reset();
        pulse(3'b010);
        check("t5_div12", bus.divisor, 12);
        p = cyc;
        bus.enable = 1'b1;
        tick(10);
        bus.enable = 1'b0;
        pulse(3'b100);
        check("t5_div_rst", bus.divisor, 10);
        r = cyc;
        bus.enable = 1'b1;
        push(r + 1, 10); push(r + 11, 10); push(r + 21, 10);
        tick(23);
        bus.enable = 1'b0;
        drain("t5_drain");

        // 6: speed_reset wins over speed_up; reset mid-period
        do_reset();
        pulse(3'b010);
        pulse(3'b010);
        check("t6_div14", bus.divisor, 14);
        pulse(3'b101);
        check("t6_prio", bus.divisor, 10);
        pulse(3'b010);
        check("t6_div12", bus.divisor, 12);
        p = cyc;
        bus.enable = 1'b1;
        push(p + 12, 12);
        tick(21);
        reset = 1'b1;
        tick(1);
        check("t6_rst_sync", bus.sync_clk, 0);
        check("t6_rst_div", bus.divisor, 10);
        tick(1);
        reset = 1'b0;
        r = cyc;
        push(r + 10, 10);
        tick(12);
        bus.enable = 1'b0;
        drain("t6_drain");

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
